// File: rtl/fir_sym_serial.sv
// Symmetric odd-length FIR filter built around one time-shared pre-adder,
// multiplier and accumulator. Each accepted sample takes H = (TAPS+1)/2 MAC
// cycles, then one OUT cycle in which the rounded, saturated result is presented.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   f_s        sample strobe, asynchronous to clk; a rising edge means a new sample
//   din        signed input sample, captured in the strobe cycle
//   coef_we    coefficient write enable (honoured only while idle)
//   coef_addr  coefficient index k (0..H-1); H-1 is the centre tap
//   coef_wdata signed coefficient value
//   coef_rdy   high while idle (coefficient writes are accepted)
//   ovr_clr    clears the sticky overrun flag
//   dout       signed filtered output, held between updates
//   dout_valid one-cycle pulse when dout updates
//   busy       high while a sample is being processed
//   overrun    sticky: a strobe arrived while not idle
module fir_sym_serial #(
    parameter int unsigned DW        = 12,
    parameter int unsigned CW        = 12,
    parameter int unsigned TAPS      = 31,
    parameter int unsigned OUT_SHIFT = 11,
    parameter int unsigned ACC_W     = 29
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               f_s,
    input  logic [DW-1:0]                      din,
    input  logic                               coef_we,
    input  logic [$clog2((TAPS+1)/2)-1:0]      coef_addr,
    input  logic [CW-1:0]                      coef_wdata,
    output logic                               coef_rdy,
    input  logic                               ovr_clr,
    output logic [DW-1:0]                      dout,
    output logic                               dout_valid,
    output logic                               busy,
    output logic                               overrun
);

    localparam int unsigned H  = (TAPS + 1) / 2;
    localparam int unsigned AW = $clog2(H);
    localparam int unsigned IW = $clog2(TAPS);
    localparam int unsigned PW = DW + 1;
    localparam int unsigned MW = PW + CW;
    localparam int unsigned SW = ACC_W + 1;

    localparam logic [AW-1:0]        K_LAST  = AW'(H - 1);
    localparam logic signed [SW-1:0] RND_ONE = SW'(1) << (OUT_SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                     pl0_q, pl1_q;
    logic                     strobe;
    logic                     start;
    logic                     mac_last;

    logic signed [DW-1:0]     x_q [TAPS];
    logic signed [CW-1:0]     c_q [H];
    logic signed [ACC_W-1:0]  acc_q;
    logic [AW-1:0]            k_q;

    logic [IW-1:0]            lo_idx, hi_idx;
    logic signed [PW-1:0]     lo_ext, hi_ext, pre_sum;
    logic signed [CW-1:0]     cur_coef;
    logic signed [MW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [SW-1:0]     rnd, shifted;
    logic signed [DW-1:0]     sat;
    logic                     addr_ok;

    // Two-flop edge detector on the sample strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl0_q <= 1'b0;
            pl1_q <= 1'b0;
        end else begin
            pl0_q <= f_s;
            pl1_q <= pl0_q;
        end
    end

    assign strobe = pl0_q & ~pl1_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        mac_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    state_d = S_MAC;
                    start   = 1'b1;
                end
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    state_d  = S_OUT;
                    mac_last = 1'b1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign coef_rdy = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

    // Pre-adder folds the mirrored taps; the centre tap has no partner
    always_comb begin
        lo_idx   = IW'(k_q);
        hi_idx   = IW'(TAPS - 1) - IW'(k_q);
        lo_ext   = PW'(x_q[lo_idx]);
        hi_ext   = PW'(x_q[hi_idx]);
        pre_sum  = (k_q == K_LAST) ? lo_ext : (lo_ext + hi_ext);
        cur_coef = c_q[k_q];
        prod     = MW'(pre_sum) * MW'(cur_coef);
        acc_sum  = acc_q + ACC_W'(prod);
    end

    // Round half up, arithmetic shift, saturate; fed from the final MAC sum
    always_comb begin
        rnd     = SW'(acc_sum) + RND_ONE;
        shifted = rnd >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat = DW'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            sat = DW'(SAT_MIN);
        end else begin
            sat = DW'(shifted);
        end
    end

    // Delay line, accumulator and tap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
            acc_q <= '0;
            k_q   <= '0;
        end else if (start) begin
            x_q[0] <= $signed(din);
            for (int i = 1; i < TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
            acc_q <= '0;
            k_q   <= '0;
        end else if (state_q == S_MAC) begin
            acc_q <= acc_sum;
            k_q   <= k_q + AW'(1);
        end
    end

    // Output register: loaded on the last MAC so it is visible during OUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= mac_last;
            if (mac_last) begin
                dout <= sat;
            end
        end
    end

    // Coefficient bank; writes only while idle and in range
    assign addr_ok = ({1'b0, coef_addr} < (AW + 1)'(H));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < H; i++) begin
                c_q[i] <= '0;
            end
        end else if (coef_we && coef_rdy && addr_ok) begin
            c_q[coef_addr] <= $signed(coef_wdata);
        end
    end

    // Sticky overrun; a new overrun wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (strobe && (state_q != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sym_serial.sv
module tb_fir_sym_serial;

    localparam int TAPS = 31;
    localparam int H    = 16;
    localparam int LAT  = 18;   // posedges from f_s rise to dout_valid seen

    logic        clk;
    logic        rst;
    logic        f_s;
    logic [11:0] din;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [11:0] coef_wdata;
    logic        coef_rdy;
    logic        ovr_clr;
    logic [11:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        overrun;

    int checks;
    int failures;

    // reference model state
    int hist [TAPS];
    int cm   [H];

    // optional side actions during send_sample
    int   drop_at, drop_val;
    int   wr_at, wr_addr, wr_data;
    logic ovr_before, rdy_seen, busy_seen;

    fir_sym_serial dut (
        .clk        (clk),
        .rst        (rst),
        .f_s        (f_s),
        .din        (din),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_rdy   (coef_rdy),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        for (int i = 0; i < H; i++) cm[i] = 0;
    endfunction

    function automatic void model_push(input int v);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endfunction

    // Full-length convolution with the mirrored coefficient set h[i] = h[TAPS-1-i]
    function automatic logic [11:0] model_out();
        longint y;
        longint r;
        int     ci;
        y = 0;
        for (int i = 0; i < TAPS; i++) begin
            ci = (i < H) ? i : (TAPS - 1 - i);
            y += longint'(hist[i]) * longint'(cm[ci]);
        end
        r = (y + 1024) >>> 11;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return 12'(r);
    endfunction

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic write_coef(input int addr, input int val);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 12'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
        cm[addr] = val;
    endtask

    task automatic set_coefs_zero();
        for (int i = 0; i < H; i++) write_coef(i, 0);
    endtask

    // Drives one strobe and waits (bounded) for the resulting dout_valid pulse
    task automatic send_sample(input int v, output logic [11:0] got, output int lat,
                               output bit pulse_ok);
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0; got = '0; lat = -1; pulse_ok = 1'b0;
        @(posedge clk); #1;
        din = 12'(v); f_s = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) f_s = 1'b0;
            if (drop_at != 0 && cyc == drop_at) begin
                ovr_before = overrun;
                din = 12'(drop_val);
                f_s = 1'b1;
            end
            if (drop_at != 0 && cyc == drop_at + 3) f_s = 1'b0;
            if (wr_at != 0 && cyc == wr_at) begin
                coef_we = 1'b1; coef_addr = 4'(wr_addr); coef_wdata = 12'(wr_data);
                rdy_seen = coef_rdy; busy_seen = busy;
            end
            if (wr_at != 0 && cyc == wr_at + 1) coef_we = 1'b0;
            if (dout_valid) begin
                seen = 1'b1; got = dout; lat = cyc;
            end
        end
        @(posedge clk); #1;
        pulse_ok = !dout_valid;
        f_s = 1'b0; coef_we = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic flush_zeros(input int n);
        logic [11:0] got; int lat; bit pk;
        for (int i = 0; i < n; i++) begin
            send_sample(0, got, lat, pk);
            model_push(0);
        end
    endtask

    task automatic test_reset();
        logic [11:0] got, exp; int lat; bit pk; bit spurious;
        for (int i = 0; i < H; i++) write_coef(i, rnd12());
        @(posedge clk); #1;
        din = 12'(1500); f_s = 1'b1;
        repeat (3) @(posedge clk);
        #1 f_s = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dout !== 12'd0 || dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0
            || coef_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: dout=%0d valid=%b busy=%b ovr=%b rdy=%b expected 0/0/0/0/1",
                     $signed(dout), dout_valid, busy, overrun, coef_rdy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (dout_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: dout_valid=1 after reset, expected no output");
        end
        for (int i = 0; i < 4; i++) begin
            int v;
            v = rnd12();
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = model_out();
            checks++;
            if (got !== exp || lat != LAT) begin
                failures++;
                $display("FAIL reset_coefs_zero[%0d]: dout=%0d lat=%0d expected %0d lat=%0d",
                         i, $signed(got), lat, $signed(exp), LAT);
            end
        end
    endtask

    task automatic test_impulse();
        logic [11:0] got, exp; int lat; bit pk;
        set_coefs_zero();
        write_coef(15, 2047);
        flush_zeros(TAPS);
        for (int n = 0; n < 20; n++) begin
            int v;
            v = (n == 0) ? 1000 : 0;
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = (n == 15) ? 12'd1000 : 12'd0;
            checks++;
            if (got !== exp || got !== model_out() || lat != LAT || !pk) begin
                failures++;
                $display("FAIL impulse[%0d]: dout=%0d lat=%0d pulse_ok=%0d expected %0d lat=%0d",
                         n, $signed(got), lat, pk, $signed(exp), LAT);
            end
        end
    endtask

    task automatic test_symmetry();
        logic [11:0] got, exp; int lat; bit pk;
        set_coefs_zero();
        write_coef(0, 1024);
        flush_zeros(TAPS);
        for (int n = 0; n < 32; n++) begin
            int v;
            v = (n == 0) ? 600 : 0;
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = (n == 0 || n == 30) ? 12'd300 : 12'd0;
            checks++;
            if (got !== exp || got !== model_out()) begin
                failures++;
                $display("FAIL symmetry[%0d]: dout=%0d expected %0d",
                         n, $signed(got), $signed(exp));
            end
        end
    endtask

    task automatic test_saturation();
        logic [11:0] got, exp; int lat; bit pk;
        set_coefs_zero();
        write_coef(15, 2047);
        write_coef(14, 2047);
        for (int n = 0; n < 40; n++) begin
            int v;
            v = (n < 20) ? 2047 : -2048;
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = model_out();
            if (n == 19) exp = 12'h7FF;
            if (n == 39) exp = 12'h800;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL saturation[%0d]: dout=%0d expected %0d",
                         n, $signed(got), $signed(exp));
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] got, exp; int lat; bit pk;
        for (int i = 0; i < H; i++) write_coef(i, rnd12());
        for (int n = 0; n < 40; n++) begin
            int v;
            v = rnd12();
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = model_out();
            checks++;
            if (got !== exp || lat != LAT) begin
                failures++;
                $display("FAIL random[%0d]: din=%0d dout=%0d lat=%0d expected %0d lat=%0d",
                         n, v, $signed(got), lat, $signed(exp), LAT);
            end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] got, exp; int lat; bit pk; int v1, v3;
        v1 = rnd12();
        drop_at = 10; drop_val = 1777;
        send_sample(v1, got, lat, pk);
        drop_at = 0;
        model_push(v1);
        exp = model_out();
        checks++;
        if (ovr_before !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: before=%b after=%b expected 0 then 1", ovr_before, overrun);
        end
        checks++;
        if (got !== exp || lat != LAT) begin
            failures++;
            $display("FAIL overrun_first_out: dout=%0d lat=%0d expected %0d lat=%0d",
                     $signed(got), lat, $signed(exp), LAT);
        end
        v3 = rnd12();
        send_sample(v3, got, lat, pk);
        model_push(v3);
        exp = model_out();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL overrun_dropped: dout=%0d expected %0d", $signed(got), $signed(exp));
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
        end
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b expected 0", overrun);
        end
    endtask

    task automatic test_coef_write_busy();
        logic [11:0] got, exp; int lat; bit pk;
        write_coef(15, 1500);
        wr_at = 5; wr_addr = 15; wr_data = -1200;
        send_sample(rnd12(), got, lat, pk);
        wr_at = 0;
        model_push(int'($signed(din)));
        exp = model_out();
        checks++;
        if (rdy_seen !== 1'b0 || busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL busy_flags: coef_rdy=%b busy=%b expected 0 1", rdy_seen, busy_seen);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL busy_write_out: dout=%0d expected %0d", $signed(got), $signed(exp));
        end
        for (int n = 0; n < 2; n++) begin
            int v;
            v = rnd12();
            send_sample(v, got, lat, pk);
            model_push(v);
            exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL busy_write_next[%0d]: dout=%0d expected %0d",
                         n, $signed(got), $signed(exp));
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        drop_at = 0; drop_val = 0; wr_at = 0; wr_addr = 0; wr_data = 0;
        ovr_before = 1'b0; rdy_seen = 1'b0; busy_seen = 1'b0;
        rst = 1'b0; f_s = 1'b0; din = '0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; ovr_clr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_impulse();
        test_symmetry();
        test_saturation();
        test_random();
        test_overrun();
        test_coef_write_busy();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
